// File: rtl/pipe_ctrl_tracker.sv
// pipe_ctrl_tracker
//   Holds the control-path pipeline registers ID/EX, EX/MEM and MEM/WB. Feeds
//   the stage-tagged write/load/destination signals back to the ID hazard and
//   forwarding logic. Also keeps saturating hazard counters and a sticky
//   forwarding-consistency error flag for debug.
//
// Ports
//   clock, reset            : clock; synchronous active-high reset
//   wreg, m2reg, wmem, jal  : ID control bits of the current instruction
//   regrt, rt, rd           : ID destination selection and register fields
//   nostall                 : 0 inserts a bubble into EX (load-use stall)
//   fwda, fwdb              : ID forward selects (00 none, 01 exe_alu, 10 mem_alu, 11 mem_lw)
//   cnt_en, cnt_clr         : counter enable and synchronous clear
//   e*/m*/w* outputs        : EX, MEM and WB stage control registers
//   stall_cnt, fwd_cnt,
//   ldfwd_cnt               : saturating hazard counters
//   fwd_err                 : sticky flag, set on a forward that the pipeline cannot supply
module pipe_ctrl_tracker #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned JAL_REG = 31
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wreg,
   input  logic             m2reg,
   input  logic             wmem,
   input  logic             jal,
   input  logic             regrt,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic             nostall,
   input  logic [1:0]       fwda,
   input  logic [1:0]       fwdb,
   input  logic             cnt_en,
   input  logic             cnt_clr,
   output logic             ewreg,
   output logic             em2reg,
   output logic             ewmem,
   output logic             ejal,
   output logic [4:0]       ern,
   output logic             mwreg,
   output logic             mm2reg,
   output logic             mwmem,
   output logic [4:0]       mrn,
   output logic             wwreg,
   output logic             wm2reg,
   output logic [4:0]       wrn,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] fwd_cnt,
   output logic [CNT_W-1:0] ldfwd_cnt,
   output logic             fwd_err
);

   localparam logic [4:0] JalRn = 5'(JAL_REG);

   logic [4:0] dest;
   logic       any_fwd;
   logic       ld_fwd;
   logic       fwd_bad;

   // A selector is inconsistent when the stage it names does not hold a
   // result of the matching kind (ALU result vs. loaded data).
   function automatic logic sel_bad(input logic [1:0] sel,
                                    input logic e_w, input logic e_l,
                                    input logic m_w, input logic m_l);
      logic bad;
      bad = 1'b0;
      unique case (sel)
         2'b01:   bad = !e_w || e_l;
         2'b10:   bad = !m_w || m_l;
         2'b11:   bad = !m_w || !m_l;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      dest    = jal ? JalRn : (regrt ? rt : rd);
      any_fwd = (fwda != 2'b00) || (fwdb != 2'b00);
      ld_fwd  = (fwda == 2'b11) || (fwdb == 2'b11);
      fwd_bad = nostall &&
                (sel_bad(fwda, ewreg, em2reg, mwreg, mm2reg) ||
                 sel_bad(fwdb, ewreg, em2reg, mwreg, mm2reg));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ewreg     <= 1'b0;
         em2reg    <= 1'b0;
         ewmem     <= 1'b0;
         ejal      <= 1'b0;
         ern       <= 5'd0;
         mwreg     <= 1'b0;
         mm2reg    <= 1'b0;
         mwmem     <= 1'b0;
         mrn       <= 5'd0;
         wwreg     <= 1'b0;
         wm2reg    <= 1'b0;
         wrn       <= 5'd0;
         stall_cnt <= '0;
         fwd_cnt   <= '0;
         ldfwd_cnt <= '0;
         fwd_err   <= 1'b0;
      end else begin
         // ID/EX: bubble on stall; non-writers carry rn=0 so they never match.
         if (nostall) begin
            ewreg  <= wreg;
            em2reg <= m2reg;
            ewmem  <= wmem;
            ejal   <= jal;
            ern    <= wreg ? dest : 5'd0;
         end else begin
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ewmem  <= 1'b0;
            ejal   <= 1'b0;
            ern    <= 5'd0;
         end

         // EX/MEM and MEM/WB drain every cycle, stalled or not.
         mwreg  <= ewreg;
         mm2reg <= em2reg;
         mwmem  <= ewmem;
         mrn    <= ern;
         wwreg  <= mwreg;
         wm2reg <= mm2reg;
         wrn    <= mrn;

         if (cnt_clr) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
            ldfwd_cnt <= '0;
         end else if (cnt_en) begin
            if (!nostall)           stall_cnt <= sat_inc(stall_cnt);
            if (nostall && any_fwd) fwd_cnt   <= sat_inc(fwd_cnt);
            if (nostall && ld_fwd)  ldfwd_cnt <= sat_inc(ldfwd_cnt);
         end

         fwd_err <= fwd_err || fwd_bad;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Bench for pipe_ctrl_tracker: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a delay-line model.
// A second instance with 2-bit counters exercises saturation.
module tb_pipe_ctrl_tracker;

   logic       clock = 1'b0;
   logic       reset, wreg, m2reg, wmem, jal, regrt, nostall, cnt_en, cnt_clr;
   logic [4:0] rt, rd;
   logic [1:0] fwda, fwdb;

   logic        ewreg, em2reg, ewmem, ejal, mwreg, mm2reg, mwmem, wwreg, wm2reg, fwd_err;
   logic [4:0]  ern, mrn, wrn;
   logic [15:0] stall_cnt, fwd_cnt, ldfwd_cnt;

   logic       s_ewreg, s_em2reg, s_ewmem, s_ejal, s_mwreg, s_mm2reg, s_mwmem;
   logic       s_wwreg, s_wm2reg, s_fwd_err;
   logic [4:0] s_ern, s_mrn, s_wrn;
   logic [1:0] s_stall_cnt, s_fwd_cnt, s_ldfwd_cnt;

   int nvec = 0;
   int nerr = 0;
   bit chk_on = 1'b0;

   always #5 clock = ~clock;

   pipe_ctrl_tracker u_dut (
      .clock(clock), .reset(reset), .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .jal(jal),
      .regrt(regrt), .rt(rt), .rd(rd), .nostall(nostall), .fwda(fwda), .fwdb(fwdb),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
      .ejal(ejal), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn),
      .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
      .ldfwd_cnt(ldfwd_cnt), .fwd_err(fwd_err)
   );

   pipe_ctrl_tracker #(.CNT_W(2)) u_sat (
      .clock(clock), .reset(reset), .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .jal(jal),
      .regrt(regrt), .rt(rt), .rd(rd), .nostall(nostall), .fwda(fwda), .fwdb(fwdb),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .ewreg(s_ewreg), .em2reg(s_em2reg),
      .ewmem(s_ewmem), .ejal(s_ejal), .ern(s_ern), .mwreg(s_mwreg), .mm2reg(s_mm2reg),
      .mwmem(s_mwmem), .mrn(s_mrn), .wwreg(s_wwreg), .wm2reg(s_wm2reg), .wrn(s_wrn),
      .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt), .ldfwd_cnt(s_ldfwd_cnt),
      .fwd_err(s_fwd_err)
   );

   // Model: an instruction's control record, as seen in a stage.
   typedef struct packed {
      logic       wr;
      logic       ld;
      logic       st;
      logic       jl;
      logic [4:0] rn;
   } rec_t;

   rec_t        stage_e, stage_m, stage_w;
   int unsigned n_stall, n_fwd, n_ldfwd;  // true event counts since last clear
   bit          err_m;

   function automatic int unsigned sat(input int unsigned n, input int unsigned maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   function automatic bit bad_sel(input logic [1:0] sel, input rec_t e, input rec_t m);
      if (sel == 2'd1) return !e.wr || e.ld;
      if (sel == 2'd2) return !m.wr || m.ld;
      if (sel == 2'd3) return !m.wr || !m.ld;
      return 1'b0;
   endfunction

   task automatic model_step();
      rec_t nr;
      if (reset) begin
         stage_e = '0; stage_m = '0; stage_w = '0;
         n_stall = 0; n_fwd = 0; n_ldfwd = 0; err_m = 1'b0;
         return;
      end
      if (nostall && (bad_sel(fwda, stage_e, stage_m) || bad_sel(fwdb, stage_e, stage_m)))
         err_m = 1'b1;
      nr = '0;
      if (nostall) begin
         nr.wr = wreg; nr.ld = m2reg; nr.st = wmem; nr.jl = jal;
         if (wreg) nr.rn = jal ? 5'd31 : (regrt ? rt : rd);
      end
      stage_w = stage_m;
      stage_m = stage_e;
      stage_e = nr;
      if (cnt_clr) begin
         n_stall = 0; n_fwd = 0; n_ldfwd = 0;
      end else if (cnt_en) begin
         if (!nostall) n_stall++;
         if (nostall && (fwda != 0 || fwdb != 0)) n_fwd++;
         if (nostall && (fwda == 3 || fwdb == 3)) n_ldfwd++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         chk("ewreg", 32'(ewreg), 32'(stage_e.wr));
         chk("em2reg", 32'(em2reg), 32'(stage_e.ld));
         chk("ewmem", 32'(ewmem), 32'(stage_e.st));
         chk("ejal", 32'(ejal), 32'(stage_e.jl));
         chk("ern", 32'(ern), 32'(stage_e.rn));
         chk("mwreg", 32'(mwreg), 32'(stage_m.wr));
         chk("mm2reg", 32'(mm2reg), 32'(stage_m.ld));
         chk("mwmem", 32'(mwmem), 32'(stage_m.st));
         chk("mrn", 32'(mrn), 32'(stage_m.rn));
         chk("wwreg", 32'(wwreg), 32'(stage_w.wr));
         chk("wm2reg", 32'(wm2reg), 32'(stage_w.ld));
         chk("wrn", 32'(wrn), 32'(stage_w.rn));
         chk("stall_cnt", 32'(stall_cnt), sat(n_stall, 65535));
         chk("fwd_cnt", 32'(fwd_cnt), sat(n_fwd, 65535));
         chk("ldfwd_cnt", 32'(ldfwd_cnt), sat(n_ldfwd, 65535));
         chk("fwd_err", 32'(fwd_err), 32'(err_m));
         chk("sat stall_cnt", 32'(s_stall_cnt), sat(n_stall, 3));
         chk("sat fwd_cnt", 32'(s_fwd_cnt), sat(n_fwd, 3));
         chk("sat ldfwd_cnt", 32'(s_ldfwd_cnt), sat(n_ldfwd, 3));
         chk("sat fwd_err", 32'(s_fwd_err), 32'(err_m));
         chk("sat ern", 32'(s_ern), 32'(stage_e.rn));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      model_step();
   endtask

   task automatic idle();
      wreg = 0; m2reg = 0; wmem = 0; jal = 0; regrt = 0; rt = 0; rd = 0;
      nostall = 1; fwda = 0; fwdb = 0; cnt_clr = 0;
   endtask

   task automatic rand_in();
      wreg = 1'($urandom); m2reg = 1'($urandom); wmem = 1'($urandom);
      jal = ($urandom_range(7) == 0); regrt = 1'($urandom);
      rt = 5'($urandom); rd = 5'($urandom);
      nostall = ($urandom_range(3) != 0);
      fwda = 2'($urandom); fwdb = 2'($urandom);
      cnt_en = ($urandom_range(4) != 0);
      cnt_clr = ($urandom_range(49) == 0);
      reset = ($urandom_range(199) == 0);
   endtask

   initial begin
      // Reset with arbitrary inputs for 2 cycles.
      rand_in();
      reset = 1;
      tick();
      chk_on = 1'b1;
      rand_in();
      reset = 1;
      tick();
      #3;
      chk("rst ern", 32'(ern), 0);
      chk("rst wwreg", 32'(wwreg), 0);
      chk("rst stall_cnt", 32'(stall_cnt), 0);
      chk("rst fwd_err", 32'(fwd_err), 0);

      // add r5: E at t+1, M at t+2, W at t+3.
      reset = 0; cnt_en = 0;
      idle();
      wreg = 1; regrt = 0; rd = 5'd5;
      tick();
      #3;
      chk("add ern", 32'(ern), 5);
      chk("add ewreg", 32'(ewreg), 1);
      idle();
      tick();
      #3;
      chk("add mrn", 32'(mrn), 5);
      tick();
      #3;
      chk("add wrn", 32'(wrn), 5);
      chk("add wwreg", 32'(wwreg), 1);

      // lw r8 followed by one stall cycle.
      cnt_en = 1;
      wreg = 1; m2reg = 1; regrt = 1; rt = 5'd8;
      tick();
      #3;
      chk("lw em2reg", 32'(em2reg), 1);
      chk("lw ern", 32'(ern), 8);
      idle();
      nostall = 0;
      tick();
      #3;
      chk("bubble ewreg", 32'(ewreg), 0);
      chk("bubble ern", 32'(ern), 0);
      chk("lw mrn", 32'(mrn), 8);
      chk("lw mm2reg", 32'(mm2reg), 1);
      chk("lw stall_cnt", 32'(stall_cnt), 1);

      // jal writes r31; sw presents rn 0.
      idle();
      jal = 1; wreg = 1; rd = 5'd3; regrt = 0;
      tick();
      #3;
      chk("jal ern", 32'(ern), 31);
      chk("jal ejal", 32'(ejal), 1);
      idle();
      wmem = 1; regrt = 1; rt = 5'd4;
      tick();
      #3;
      chk("sw ewmem", 32'(ewmem), 1);
      chk("sw ern", 32'(ern), 0);

      // Forward counters, clear, stall saturation.
      idle();
      cnt_clr = 1;
      tick();
      cnt_clr = 0; fwda = 2'd3; fwdb = 2'd1;
      repeat (3) tick();
      #3;
      chk("fwd_cnt 3", 32'(fwd_cnt), 3);
      chk("ldfwd_cnt 3", 32'(ldfwd_cnt), 3);
      idle();
      cnt_clr = 1;
      tick();
      #3;
      chk("clr fwd_cnt", 32'(fwd_cnt), 0);
      chk("clr ldfwd_cnt", 32'(ldfwd_cnt), 0);
      cnt_clr = 0; nostall = 0;
      repeat (5) tick();
      #3;
      chk("stall_cnt 5", 32'(stall_cnt), 5);
      chk("sat stall_cnt 3", 32'(s_stall_cnt), 3);

      // Sticky forwarding error.
      idle();
      reset = 1;
      tick();
      reset = 0;
      tick();
      #3;
      chk("err clear", 32'(fwd_err), 0);
      fwda = 2'd1;
      tick();
      #3;
      chk("err set", 32'(fwd_err), 1);
      fwda = 2'd0; cnt_clr = 1;
      tick();
      #3;
      chk("err after clr", 32'(fwd_err), 1);
      cnt_clr = 0; reset = 1;
      tick();
      #3;
      chk("err after reset", 32'(fwd_err), 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         tick();
      end
      #6;
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_tracker.md
Name: pipe_ctrl_tracker

Overview:
- Owns the control-path pipeline registers downstream of the ID-stage control unit: ID/EX, EX/MEM and MEM/WB.
- Consumes the per-instruction control bits and the stall/forward decisions made in ID. Returns the stage-tagged signals that the ID hazard/forwarding logic depends on (ewreg, em2reg, ern, mwreg, mm2reg, mrn).
- Also keeps saturating hazard performance counters and a sticky forwarding-consistency error flag for debug.

Parameters:
CNT_W, 16, width of each performance counter
JAL_REG, 31, destination register number written by jal

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
wreg  in  1  ID: instruction writes a register (already gated by nostall)
m2reg  in  1  ID: write-back data comes from memory (load)
wmem  in  1  ID: instruction writes memory
jal  in  1  ID: instruction is jal
regrt  in  1  ID: destination is rt (1) or rd (0)
rt  in  5  ID: rt field
rd  in  5  ID: rd field
nostall  in  1  ID: 0 = load-use stall this cycle
fwda  in  2  ID: operand A forward select (00 none, 01 exe_alu, 10 mem_alu, 11 mem_lw)
fwdb  in  2  ID: operand B forward select, same encoding
cnt_en  in  1  counter enable
cnt_clr  in  1  synchronous counter clear
ewreg  out  1  EX: write-register flag
em2reg  out  1  EX: load flag
ewmem  out  1  EX: memory-write flag
ejal  out  1  EX: jal flag
ern  out  5  EX: destination register number
mwreg  out  1  MEM: write-register flag
mm2reg  out  1  MEM: load flag
mwmem  out  1  MEM: memory-write flag
mrn  out  5  MEM: destination register number
wwreg  out  1  WB: write-register flag
wm2reg  out  1  WB: load flag
wrn  out  5  WB: destination register number
stall_cnt  out  CNT_W  cycles with nostall=0
fwd_cnt  out  CNT_W  non-stalled cycles with any forward active
ldfwd_cnt  out  CNT_W  non-stalled cycles with any 11 (mem_lw) forward
fwd_err  out  1  sticky forwarding-consistency error

Behaviour:
- Reset (reset=1 at an edge): every output goes to 0 and all counters clear. Reset overrides everything, including mid-stall.
- Destination mux: dest = JAL_REG if jal, else rt if regrt, else rd.
- ID/EX update, each edge:
  - nostall=0: insert a bubble. ewreg, em2reg, ewmem, ejal and ern all become 0.
  - nostall=1: ewreg<=wreg, em2reg<=m2reg, ewmem<=wmem, ejal<=jal.
  - ern<=dest when wreg=1, else ern<=0. A non-writing instruction must never present a matchable register number.
- EX/MEM advances every cycle; stalls do not freeze it: mwreg<=ewreg, mm2reg<=em2reg, mwmem<=ewmem, mrn<=ern.
- MEM/WB advances every cycle: wwreg<=mwreg, wm2reg<=mm2reg, wrn<=mrn.
- Latency: ID control appears on the E outputs 1 cycle later, M outputs 2 cycles later, W outputs 3 cycles later. A stalled cycle produces exactly one bubble per stall cycle. A consecutive stall run of N cycles produces N bubbles.
- Counters, priority reset > cnt_clr > increment:
  - Increment only when cnt_en=1. Each counter saturates at 2^CNT_W-1 with no wrap.
  - stall_cnt: +1 when nostall=0.
  - fwd_cnt: +1 when nostall=1 and (fwda!=0 or fwdb!=0).
  - ldfwd_cnt: +1 when nostall=1 and (fwda==11 or fwdb==11).
  - A cycle with both operands forwarded counts once.
- fwd_err is evaluated each cycle against the current E/M outputs.
  - It is set when any selector is inconsistent with those outputs:
    - sel=01 with ewreg=0 or em2reg=1;
    - sel=10 with mwreg=0 or mm2reg=1;
    - sel=11 with mwreg=0 or mm2reg=0.
  - Evaluated only when nostall=1. Once set, fwd_err stays 1 until reset; cnt_clr does not clear it.
- Simultaneous events: a stall and a drain of EX/MEM in the same cycle are both honoured. The bubble enters EX while the previous EX contents move to MEM.

Test Plan:
- Reset held 2 cycles with arbitrary inputs -> all outputs 0; counters 0; fwd_err 0.
- Issue add (wreg=1, regrt=0, rd=5), nostall=1 -> ern=5/ewreg=1 at t+1, mrn=5 at t+2, wrn=5/wwreg=1 at t+3.
- Issue lw (wreg=1, m2reg=1, regrt=1, rt=8), then hold nostall=0 for 1 cycle -> em2reg=1/ern=8 at t+1. At t+2 EX holds a bubble (ewreg=0, ern=0) while M shows mrn=8/mm2reg=1. stall_cnt=1.
- jal (jal=1, wreg=1, rd=3, regrt=0) -> ern=31. sw (wreg=0, wmem=1, rt=4) -> ewmem=1, ern=0.
- With cnt_en=1: fwda=11 with fwdb=01 for 3 non-stall cycles -> fwd_cnt=3, ldfwd_cnt=3. Then cnt_clr=1 -> all counters 0 next cycle. With CNT_W=2 and 5 stall cycles -> stall_cnt saturates at 3.
- fwda=01 while ewreg=0 and nostall=1 -> fwd_err=1 next cycle. Remains 1 after cnt_clr; clears only on reset.
